spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
- Front-end for the register bank. Oversamples the MCU SPI pins (spi_clk, spi_cs, spi_special, spi_mosi) in the XTALCLK domain and assembles one MSB-bit command frame.
- On a well-formed frame it emits a single-cycle strobe carrying addr (high byte) and val (low byte).
- Shifts a readback word out on spi_miso during the same frame.
- Replaces the SPI-clock-domain capture. Downstream decode (set/clear/toggle update) consumes frame_valid/frame_addr/frame_val synchronously.

Parameters:
- MSB, 16, frame length in bits; addr = bits [MSB-1:8], val = bits [7:0].
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock (XTALCLK); must be at least 4x spi_clk.
- rst_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  raw SPI clock pin, CPOL=0.
- spi_cs  in  1  raw chip select, active low.
- spi_special  in  1  raw register-bank select, active low.
- spi_mosi  in  1  raw serial data in.
- spi_miso  out  1  serial readback out.
- tx_data  in  MSB  readback word; sampled at frame start.
- frame_valid  out  1  one-cycle strobe: complete frame received.
- frame_addr  out  8  address byte; held until the next valid frame.
- frame_val  out  8  value byte; held until the next valid frame.
- frame_err  out  1  one-cycle strobe: frame ended with wrong bit count or aborted.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset: the clock is one clk, and reset is asynchronous and active-low.
  - All outputs are 0 and all synchronisers are cleared to the deasserted level (spi_cs=1, spi_special=1, spi_clk=0).
  - State goes to WAIT_IDLE.
- Synchronisation: every raw input passes through SYNC_STAGES flops. Edge detect on synced spi_clk and spi_cs compares against one further registered copy.
- States:
  - WAIT_IDLE: hold until synced cs=1, then go to IDLE. This guarantees that reset in mid-frame never yields a partial frame.
  - IDLE: on cs falling edge with synced special=0, load tx_shift<=tx_data, clear bit count, set busy, go to SHIFT. If cs falls with special=1, stay in IDLE; that transaction is a passthrough and is ignored.
  - SHIFT:
    - On each spi_clk falling edge: rx_shift<={rx_shift[MSB-2:0], mosi}, tx_shift<<=1 (zero fill), and count++. The count saturates at MSB+1.
    - If special goes high: pulse frame_err and go to WAIT_IDLE.
    - On cs rising edge: go to DONE.
  - DONE (one cycle):
    - If count==MSB: latch frame_addr/frame_val from rx_shift and pulse frame_valid.
    - Otherwise: pulse frame_err and leave frame_addr/frame_val unchanged.
    - Clear busy and go to IDLE.
- spi_miso is registered and equals tx_shift[MSB-1]. The first bit is valid before the first rising spi_clk; the master samples on rising and the block updates after falling. spi_miso is driven 0 whenever state != SHIFT.
- Latency: frame_valid asserts SYNC_STAGES+2 clk cycles after the raw cs rising edge.
- Simultaneous events:
  - A spi_clk falling edge in the same cycle as the cs rising edge is counted before completion.
  - A cs falling edge in the DONE cycle is missed by design; the master must hold cs high for at least SYNC_STAGES+3 clk cycles.
- Overrun: more than MSB clocks gives count>MSB, which is frame_err. Bits are still shifted, so rx_shift holds the last MSB bits, but they are discarded.
- Width: frame_addr = rx_shift[MSB-1:MSB-8], frame_val = rx_shift[7:0]. MSB<16 is unsupported.

Optional Feature:
- SPI_FRAME_RX_READBACK_EN
  - Defined: spi_miso behaves as above from tx_data.
  - Undefined: tx_shift logic is removed, tx_data is ignored, and spi_miso is constant 0.

Decomposition:
- Shared package spi_frame_pkg holds:
  - FRAME_BITS=16 and ADDR_BITS=8.
  - The state enum {WAIT_IDLE, IDLE, SHIFT, DONE}.
  - Register address constants (LED=7, MUX=8, DAC=9, RAILS=10, SOFT_RESET=11, ...) reused by the decoder.
- One sub-module, sync_edge: a SYNC_STAGES synchroniser plus rise/fall pulses. It is instantiated for spi_clk and spi_cs; plain synchronisers are used for mosi and special.

Test Plan:
- Frame 0x070F with special=0, clk=8x spi_clk -> exactly one frame_valid, frame_addr=0x07, frame_val=0x0F, frame_err=0.
- tx_data=0xA55A with readback enabled during frame 0x0800 -> master samples 1010010101011010 on spi_miso; spi_miso=0 after cs high.
- 15 clocks, then 17 clocks -> two frame_err pulses, no frame_valid, and frame_addr/frame_val retain the prior 0x07/0x0F.
- cs low with special=1, 16 clocks of 0xFFFF -> no strobe, busy=0 throughout, spi_miso=0.
- rst_n pulsed low after 8 bits, then the remaining 8 bits and cs high -> no strobe. The following full frame 0x0A03 gives frame_valid with addr 0x0A, val 0x03.
- special raised mid-frame at bit 5 -> one frame_err; the next frame 0x0C01 is received correctly.

Source files
------------

// File: rtl/spi_frame_rx_pkg.sv
// Shared definitions for the SPI register-bank front-end and its downstream decoder.
package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 8;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Register map consumed by the set/clear/toggle decoder
    localparam logic [ADDR_BITS-1:0] REG_LED        = 8'd7;
    localparam logic [ADDR_BITS-1:0] REG_MUX        = 8'd8;
    localparam logic [ADDR_BITS-1:0] REG_DAC        = 8'd9;
    localparam logic [ADDR_BITS-1:0] REG_RAILS      = 8'd10;
    localparam logic [ADDR_BITS-1:0] REG_SOFT_RESET = 8'd11;

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchroniser for one raw pin plus single-cycle rise/fall pulses.
// RESET_VAL is the pin's idle level, so reset never fabricates an edge.
module sync_edge
    import spi_frame_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampled SPI frame receiver feeding the register bank; clk must run >= 4x spi_clk.
// Define SPI_FRAME_RX_READBACK_EN to shift i_tx_data out on o_spi_miso; otherwise MISO is tied low.
//
// state     | meaning
// WAIT_IDLE | after reset or abort: wait for settled synchronisers and cs high
// IDLE      | wait for cs falling with special low
// SHIFT     | frame in progress, one bit per spi_clk falling edge
// DONE      | one cycle: publish frame or flag error
module spi_frame_rx
    import spi_frame_pkg::*;
#(
    parameter int MSB         = FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_spi_clk,
    input  logic                 i_spi_cs,
    input  logic                 i_spi_special,
    input  logic                 i_spi_mosi,
    output logic                 o_spi_miso,
    input  logic [MSB-1:0]       i_tx_data,
    output logic                 o_frame_valid,
    output logic [ADDR_BITS-1:0] o_frame_addr,
    output logic [ADDR_BITS-1:0] o_frame_val,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int               CNT_W    = $clog2(MSB + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MSB);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MSB + 1);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_unused_sync;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_din   (i_spi_clk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_din   (i_spi_cs),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    assign w_unused_sync = w_sclk_level ^ w_sclk_rise;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_special_sync;
    logic [SYNC_STAGES:0]   r_settle;
    logic                   w_mosi;
    logic                   w_special;

    // r_settle fills once the synchroniser chains hold real pin values rather than reset levels,
    // so a reset during an active frame cannot be mistaken for a fresh cs falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mosi_sync    <= '0;
            r_special_sync <= '1;
            r_settle       <= '0;
        end else begin
            r_mosi_sync    <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_special_sync <= {r_special_sync[SYNC_STAGES-2:0], i_spi_special};
            r_settle       <= {r_settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_special = r_special_sync[SYNC_STAGES-1];

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_count, w_count_next;
    logic [MSB-1:0]       r_rx_shift, w_rx_next;
    logic                 w_load_tx, w_shift_en;
    logic                 w_valid_next, w_err_next;
    logic                 r_busy, r_frame_valid, r_frame_err;
    logic [ADDR_BITS-1:0] r_frame_addr, r_frame_val;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_rx_next    = r_rx_shift;
        w_load_tx    = 1'b0;
        w_shift_en   = 1'b0;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                if (r_settle[SYNC_STAGES] && w_cs_level)
                    w_state_next = IDLE;
            end
            IDLE: begin
                if (w_cs_fall && !w_special) begin
                    w_state_next = SHIFT;
                    w_count_next = '0;
                    w_load_tx    = 1'b1;
                end
            end
            SHIFT: begin
                // A clock edge coinciding with cs rising is still counted before DONE
                if (w_sclk_fall) begin
                    w_rx_next  = {r_rx_shift[MSB-2:0], w_mosi};
                    w_shift_en = 1'b1;
                    if (r_count != CNT_SAT)
                        w_count_next = r_count + CNT_W'(1);
                end
                if (w_special) begin
                    w_err_next   = 1'b1;
                    w_state_next = WAIT_IDLE;
                end else if (w_cs_rise) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (r_count == CNT_FULL)
                    w_valid_next = 1'b1;
                else
                    w_err_next = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= WAIT_IDLE;
            r_count       <= '0;
            r_rx_shift    <= '0;
            r_busy        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_addr  <= '0;
            r_frame_val   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_rx_shift    <= w_rx_next;
            r_busy        <= (w_state_next == SHIFT) || (w_state_next == DONE);
            r_frame_valid <= w_valid_next;
            r_frame_err   <= w_err_next;
            if (w_valid_next) begin
                r_frame_addr <= r_rx_shift[MSB-1 -: ADDR_BITS];
                r_frame_val  <= r_rx_shift[ADDR_BITS-1:0];
            end
        end
    end

    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;
    assign o_frame_addr  = r_frame_addr;
    assign o_frame_val   = r_frame_val;
    assign o_busy        = r_busy;

`ifdef SPI_FRAME_RX_READBACK_EN
    logic [MSB-1:0] r_tx_shift, w_tx_next;
    logic           r_miso;

    always_comb begin
        w_tx_next = r_tx_shift;
        if (w_load_tx)
            w_tx_next = i_tx_data;
        else if (w_shift_en)
            w_tx_next = {r_tx_shift[MSB-2:0], 1'b0};
    end

    // MISO follows the next shift value so the first bit is out before the first rising spi_clk
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_shift <= '0;
            r_miso     <= 1'b0;
        end else begin
            r_tx_shift <= w_tx_next;
            r_miso     <= (w_state_next == SHIFT) ? w_tx_next[MSB-1] : 1'b0;
        end
    end

    assign o_spi_miso = r_miso;
`else
    logic w_unused_tx;

    assign w_unused_tx = ^{i_tx_data, w_load_tx, w_shift_en};
    assign o_spi_miso  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: clk 100 MHz, spi_clk at 1/8 of clk, expected values hand-computed.
module tb_spi_frame_rx;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        spi_clk     = 1'b0;
    logic        spi_cs      = 1'b1;
    logic        spi_special = 1'b1;
    logic        spi_mosi    = 1'b0;
    logic [15:0] tx_data     = 16'h0000;
    logic        spi_miso;
    logic        frame_valid;
    logic [7:0]  frame_addr;
    logic [7:0]  frame_val;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_busy   = 0;
    int n_miso   = 0;
    int v0, e0, b0, m0;
    logic [15:0] miso_word;
    logic [15:0] exp_rb;

    spi_frame_rx dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_spi_clk     (spi_clk),
        .i_spi_cs      (spi_cs),
        .i_spi_special (spi_special),
        .i_spi_mosi    (spi_mosi),
        .o_spi_miso    (spi_miso),
        .i_tx_data     (tx_data),
        .o_frame_valid (frame_valid),
        .o_frame_addr  (frame_addr),
        .o_frame_val   (frame_val),
        .o_frame_err   (frame_err),
        .o_busy        (busy)
    );

    // posedges at 5,15,...; all stimulus moves on multiples of 10 (negedges)
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) n_valid <= n_valid + 1;
        if (frame_err)   n_err   <= n_err + 1;
        if (busy)        n_busy  <= n_busy + 1;
        if (spi_miso)    n_miso  <= n_miso + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
        b0 = n_busy;
        m0 = n_miso;
    endtask

    task automatic cs_start(input logic special);
        spi_special = special;
        #20 spi_cs = 1'b0;
        #40;
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            #20 spi_mosi = data[i];
            #20 spi_clk = 1'b1;
            miso_word = {miso_word[14:0], spi_miso};
            #40 spi_clk = 1'b0;
        end
    endtask

    task automatic cs_end();
        #40 spi_cs = 1'b1;
        #100;
    endtask

    initial begin
`ifdef SPI_FRAME_RX_READBACK_EN
        exp_rb = 16'hA55A;
`else
        exp_rb = 16'h0000;
`endif
        #30;
        chk("rst_valid", frame_valid, 0);
        chk("rst_err",   frame_err,   0);
        chk("rst_busy",  busy,        0);
        chk("rst_miso",  spi_miso,    0);
        chk("rst_addr",  frame_addr,  0);
        chk("rst_val",   frame_val,   0);
        #10 rst_n = 1'b1;
        #100;

        // good frame 0x070F plus strobe latency from raw cs rise
        snap();
        cs_start(1'b0);
        send_bits(32'h070F, 16);
        chk("t1_busy_mid", busy, 1);
        #40 spi_cs = 1'b1;
        #30 chk("t1_valid_early", frame_valid, 0);
        #10 chk("t1_valid_lat",   frame_valid, 1);
        #100;
        chk("t1_valid_cnt", n_valid - v0, 1);
        chk("t1_err_cnt",   n_err - e0,   0);
        chk("t1_addr",      frame_addr,   8'h07);
        chk("t1_val",       frame_val,    8'h0F);
        chk("t1_busy_end",  busy,         0);

        // short and overrun frames
        snap();
        cs_start(1'b0);
        send_bits(32'h1234, 15);
        cs_end();
        cs_start(1'b0);
        send_bits(32'h1FFFF, 17);
        cs_end();
        chk("t3_err_cnt",   n_err - e0,   2);
        chk("t3_valid_cnt", n_valid - v0, 0);
        chk("t3_addr",      frame_addr,   8'h07);
        chk("t3_val",       frame_val,    8'h0F);

        // readback word on MISO during frame 0x0800
        tx_data   = 16'hA55A;
        miso_word = 16'h0000;
        snap();
        cs_start(1'b0);
        send_bits(32'h0800, 16);
        cs_end();
        chk("t2_miso_word", miso_word,    exp_rb);
        chk("t2_miso_idle", spi_miso,     0);
        chk("t2_valid_cnt", n_valid - v0, 1);
        chk("t2_addr",      frame_addr,   8'h08);
        chk("t2_val",       frame_val,    8'h00);

        // passthrough transaction with special high
        snap();
        cs_start(1'b1);
        send_bits(32'hFFFF, 16);
        cs_end();
        chk("t4_valid_cnt", n_valid - v0, 0);
        chk("t4_err_cnt",   n_err - e0,   0);
        chk("t4_busy_cnt",  n_busy - b0,  0);
        chk("t4_miso_cnt",  n_miso - m0,  0);

        // reset in mid-frame, then a clean frame 0x0A03
        snap();
        cs_start(1'b0);
        send_bits(32'h55, 8);
        rst_n = 1'b0;
        #20 rst_n = 1'b1;
        send_bits(32'hAA, 8);
        cs_end();
        chk("t5_valid_cnt", n_valid - v0, 0);
        chk("t5_err_cnt",   n_err - e0,   0);
        chk("t5_addr_rst",  frame_addr,   8'h00);
        snap();
        cs_start(1'b0);
        send_bits(32'h0A03, 16);
        cs_end();
        chk("t5b_valid_cnt", n_valid - v0, 1);
        chk("t5b_addr",      frame_addr,   8'h0A);
        chk("t5b_val",       frame_val,    8'h03);

        // special raised at bit 5 aborts, next frame 0x0C01 is clean
        snap();
        cs_start(1'b0);
        send_bits(32'h1F, 5);
        #40 spi_special = 1'b1;
        #100 spi_cs = 1'b1;
        #100;
        chk("t6_err_cnt",   n_err - e0,   1);
        chk("t6_valid_cnt", n_valid - v0, 0);
        snap();
        cs_start(1'b0);
        send_bits(32'h0C01, 16);
        cs_end();
        chk("t6b_valid_cnt", n_valid - v0, 1);
        chk("t6b_err_cnt",   n_err - e0,   0);
        chk("t6b_addr",      frame_addr,   8'h0C);
        chk("t6b_val",       frame_val,    8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
